// File: rtl/xadc_seq_ctrl_pkg.sv
// Shared definitions for the XADC aux-channel sequencer: FSM states, channel offset, DRP result field.
// No logic; imported by the interface, the accumulator and the top.
package xadc_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_EOC  = 2'd1,
        ST_WAIT_DRDY = 2'd2,
        ST_UPDATE    = 2'd3
    } state_t;

    localparam int AUX_CH_OFFSET = 16;
    localparam int RESULT_MSB    = 15;
    localparam int RESULT_LSB    = 4;
    localparam int RESULT_W      = RESULT_MSB - RESULT_LSB + 1;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xadc_seq_ctrl_if.sv
// XADC-side bus of the sequencer: EOC/channel and DRP port in, averaged result strobe out.
// master = sequencer, slave = XADC plus result consumers.
interface xadc_seq_ctrl_if
    import xadc_seq_ctrl_pkg::*;
#(
    parameter int N_CH = 4
);
    localparam int CHW = ch_width(N_CH);

    logic                eoc;
    logic [4:0]          channel;
    logic                drdy;
    logic [15:0]         drp_do;
    logic                den;
    logic                dwe;
    logic [6:0]          daddr;
    logic [15:0]         di;
    logic [RESULT_W-1:0] sample;
    logic [CHW-1:0]      sample_ch;
    logic                sample_vld;
    logic                busy;
    logic                err;

    modport master (
        input  eoc, channel, drdy, drp_do,
        output den, dwe, daddr, di, sample, sample_ch, sample_vld, busy, err
    );

    modport slave (
        output eoc, channel, drdy, drp_do,
        input  den, dwe, daddr, di, sample, sample_ch, sample_vld, busy, err
    );

endinterface

// File: rtl/xadc_seq_ctrl_avg_acc.sv
// Per-channel boxcar accumulator of 2^AVG_LOG2 samples; full means the next add completes a block.
// Latency: avg is combinational from acc + din so the result is usable in the add cycle.
// Backpressure: none; add and clr are single-cycle commands, clr has priority.
module adc_avg_acc
    import xadc_seq_ctrl_pkg::*;
#(
    parameter int AVG_LOG2 = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                add,
    input  logic                clr,
    input  logic [RESULT_W-1:0] din,
    output logic                full,
    output logic [RESULT_W-1:0] avg
);
    localparam int ACC_W = RESULT_W + AVG_LOG2;
    localparam int LAST  = (1 << AVG_LOG2) - 1;

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  sum;
    logic [AVG_LOG2:0] cnt;

    // acc is wide enough for 2^AVG_LOG2 full-scale samples, so sum cannot wrap
    assign sum  = acc + ACC_W'(din);
    assign full = (32'(cnt) == LAST);
    assign avg  = sum[ACC_W-1:AVG_LOG2];

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            acc <= '0;
            cnt <= '0;
        end else if (add) begin
            if (full) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/xadc_seq_ctrl.sv
// Sequences DRP reads of XADC aux channels on EOC and publishes a per-channel boxcar average.
// Latency: EOC sampled at edge t -> DEN high t+1 -> DRDY at t+1+d -> sample_vld at t+2+d.
// Backpressure: none; EOCs arriving while a read is outstanding are dropped. XADC_SEQ_TIMEOUT_EN adds the DRDY timeout.
module xadc_seq_ctrl
    import xadc_seq_ctrl_pkg::*;
#(
    parameter int         N_CH      = 4,
    parameter int         AVG_LOG2  = 3,
    parameter logic [6:0] BASE_ADDR = 7'h10,
    parameter int         TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_CH-1:0]   ch_mask,
    xadc_seq_ctrl_if.master   bus
);
    localparam int CHW    = ch_width(N_CH);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

`ifdef XADC_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    state_t              state, state_nxt;
    logic                accept;
    logic [4:0]          ch_idx;
    logic [15:0]         mask_ext;
    logic                ch_ok;
    logic [CHW-1:0]      k;
    logic [RESULT_W-1:0] rd_dat;
    logic [RESULT_W-1:0] sample_q;
    logic [CHW-1:0]      sample_ch_q;
    logic                den_q;
    logic [6:0]          daddr_q;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                err_q;
    logic                to_hit;
    logic                vld;
    logic [N_CH-1:0]     add;
    logic [N_CH-1:0]     clr;
    logic [N_CH-1:0]     full;
    logic [RESULT_W-1:0] avg [N_CH];

    assign ch_idx   = bus.channel - 5'(AUX_CH_OFFSET);
    assign mask_ext = 16'(ch_mask);
    assign ch_ok    = (bus.channel >= 5'(AUX_CH_OFFSET)) && (32'(ch_idx) < N_CH) && mask_ext[ch_idx[3:0]];

    // Without the timeout option TO_EN folds to_hit and err to constant 0
    assign to_hit = TO_EN && (state == ST_WAIT_DRDY) && !bus.drdy && (32'(wait_cnt) == TIMEOUT - 1);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en) state_nxt = ST_WAIT_EOC;
            end
            ST_WAIT_EOC: begin
                if (!en) begin
                    state_nxt = ST_IDLE;
                end else if (bus.eoc && ch_ok) begin
                    accept    = 1'b1;
                    state_nxt = ST_WAIT_DRDY;
                end
            end
            ST_WAIT_DRDY: begin
                if (bus.drdy)   state_nxt = ST_UPDATE;
                else if (to_hit) state_nxt = ST_WAIT_EOC;
            end
            ST_UPDATE: begin
                state_nxt = en ? ST_WAIT_EOC : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A read for a channel masked off in flight still completes but is neither added nor published
    assign vld = (state == ST_UPDATE) && mask_ext[4'(k)] && full[k];

    genvar i;
    generate
        for (i = 0; i < N_CH; i++) begin : g_ch
            assign add[i] = (state == ST_UPDATE) && (k == CHW'(i)) && ch_mask[i];
            assign clr[i] = (state_nxt == ST_IDLE) || !ch_mask[i];

            adc_avg_acc #(
                .AVG_LOG2 (AVG_LOG2)
            ) u_acc (
                .clk  (clk),
                .rst  (rst),
                .add  (add[i]),
                .clr  (clr[i]),
                .din  (rd_dat),
                .full (full[i]),
                .avg  (avg[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            den_q       <= 1'b0;
            daddr_q     <= '0;
            k           <= '0;
            rd_dat      <= '0;
            sample_q    <= '0;
            sample_ch_q <= '0;
            wait_cnt    <= '0;
            err_q       <= 1'b0;
        end else begin
            state    <= state_nxt;
            den_q    <= accept;
            wait_cnt <= (state == ST_WAIT_DRDY) ? wait_cnt + 1'b1 : '0;
            if (to_hit) err_q <= 1'b1;
            if (accept) begin
                daddr_q <= BASE_ADDR + 7'(ch_idx);
                k       <= CHW'(ch_idx);
            end
            if ((state == ST_WAIT_DRDY) && bus.drdy)
                rd_dat <= bus.drp_do[RESULT_MSB:RESULT_LSB];
            if (vld) begin
                sample_q    <= avg[k];
                sample_ch_q <= k;
            end
        end
    end

    assign bus.den        = den_q;
    assign bus.dwe        = 1'b0;
    assign bus.di         = '0;
    assign bus.daddr      = daddr_q;
    assign bus.busy       = (state == ST_WAIT_DRDY);
    assign bus.err        = err_q;
    assign bus.sample_vld = vld;
    assign bus.sample     = vld ? avg[k] : sample_q;
    assign bus.sample_ch  = vld ? k : sample_ch_q;

endmodule

// File: tb/tb_xadc_seq_ctrl.sv
// Bench for xadc_seq_ctrl (N_CH=4, AVG_LOG2=3): directed scenarios then random EOC/DRDY traffic
// checked against a per-channel sample-queue reference model.
module tb_xadc_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] ch_mask;

    xadc_seq_ctrl_if #(.N_CH(4)) bus ();

    xadc_seq_ctrl #(
        .N_CH      (4),
        .AVG_LOG2  (3),
        .BASE_ADDR (7'h10),
        .TIMEOUT   (64)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .ch_mask (ch_mask),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int last_sample = 0;
    int last_ch = 0;
    int q [4][$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void clear_all();
        for (int c = 0; c < 4; c++) q[c].delete();
    endfunction

    // Reference: each channel collects its samples; the 8th one yields the truncated mean of the block
    function automatic void model_push(input int ch, input int data, output bit vld, output int avg);
        int sum;
        vld = 1'b0;
        avg = 0;
        q[ch].push_back(data);
        if (q[ch].size() == 8) begin
            sum = 0;
            foreach (q[ch][j]) sum += q[ch][j];
            avg = sum / 8;
            vld = 1'b1;
            q[ch].delete();
        end
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            bus.eoc     = 1'($urandom);
            bus.channel = 5'h10;
            bus.drdy    = 1'($urandom);
            bus.drp_do  = 16'($urandom);
        end
        chk("rst_den", bus.den, 0);
        chk("rst_sample", bus.sample, 0);
        chk("rst_sample_ch", bus.sample_ch, 0);
        chk("rst_vld", bus.sample_vld, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_daddr", bus.daddr, 0);
        bus.eoc  = 1'b0;
        bus.drdy = 1'b0;
        rst = 1'b1;
        clear_all();
        last_sample = 0;
        last_ch = 0;
        @(negedge clk);
    endtask

    task automatic do_read(input logic [4:0] chn, input logic [11:0] data, input int d, input bit drop_en);
        bit acc;
        bit exp_vld;
        int exp_avg;
        int ci;
        ci  = int'(chn) - 16;
        acc = (en && ci >= 0 && ci < 4) ? ch_mask[ci] : 1'b0;
        @(negedge clk);
        bus.eoc     = 1'b1;
        bus.channel = chn;
        @(negedge clk);
        bus.eoc     = 1'b0;
        bus.channel = 5'($urandom);
        chk("den", bus.den, 32'(acc));
        if (!acc) begin
            chk("busy_reject", bus.busy, 0);
            return;
        end
        chk("daddr", bus.daddr, 32'(7'h10 + ci));
        chk("busy", bus.busy, 1);
        if (drop_en) en = 1'b0;
        @(negedge clk);
        chk("den_pulse", bus.den, 0);
        repeat (d - 1) @(negedge clk);
        bus.drdy   = 1'b1;
        bus.drp_do = {data, 4'($urandom)};
        @(negedge clk);
        bus.drdy = 1'b0;
        model_push(ci, int'(data), exp_vld, exp_avg);
        chk("vld", bus.sample_vld, 32'(exp_vld));
        if (exp_vld) begin
            chk("sample", bus.sample, exp_avg);
            chk("sample_ch", bus.sample_ch, ci);
            last_sample = exp_avg;
            last_ch = ci;
        end
        chk("busy_done", bus.busy, 0);
        @(negedge clk);
        chk("vld_pulse", bus.sample_vld, 0);
        chk("sample_hold", bus.sample, last_sample);
        chk("sample_ch_hold", bus.sample_ch, last_ch);
        if (drop_en) begin
            clear_all();
            en = 1'b1;
        end
    endtask

    initial begin
        logic [3:0] new_mask;
        logic [4:0] rch;
        int n;
        en          = 1'b0;
        ch_mask     = 4'b0000;
        bus.eoc     = 1'b0;
        bus.channel = 5'h0;
        bus.drdy    = 1'b0;
        bus.drp_do  = 16'h0;

        do_reset();
        en = 1'b1;
        @(negedge clk);

        // Constant full-scale-half samples on ch0
        ch_mask = 4'b0001;
        for (int i = 0; i < 8; i++) do_read(5'h10, 12'h800, 4, 1'b0);

        // Ramp 0..7 averages to 3; masked and out-of-range channels get no DEN
        for (int i = 0; i < 8; i++) do_read(5'h10, 12'(i), 2, 1'b0);
        ch_mask = 4'b0101;
        do_read(5'h11, 12'hABC, 2, 1'b0);
        do_read(5'h08, 12'hABC, 2, 1'b0);

        // Interleaved ch0/ch2 with independent counts
        for (int i = 0; i < 8; i++) begin
            do_read(5'h10, 12'h100, 1 + int'($urandom % 4), 1'b0);
            if (i < 5) do_read(5'h12, 12'h300, 1 + int'($urandom % 4), 1'b0);
        end
        for (int i = 0; i < 3; i++) do_read(5'h12, 12'h300, 2, 1'b0);

        // Reset while a read is outstanding; late DRDY must be ignored
        for (int i = 0; i < 3; i++) do_read(5'h10, 12'hFFF, 2, 1'b0);
        @(negedge clk);
        bus.eoc     = 1'b1;
        bus.channel = 5'h10;
        @(negedge clk);
        bus.eoc = 1'b0;
        chk("rst_mid_den", bus.den, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clear_all();
        last_sample = 0;
        last_ch = 0;
        bus.drdy   = 1'b1;
        bus.drp_do = 16'h7770;
        @(negedge clk);
        bus.drdy = 1'b0;
        chk("rst_mid_vld", bus.sample_vld, 0);
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_sample", bus.sample, 0);
        for (int i = 0; i < 8; i++) do_read(5'h10, 12'h555, 3, 1'b0);

        // EN dropping mid-read: the read completes, then all partial averages are lost
        ch_mask = 4'b1111;
        for (int i = 0; i < 7; i++) do_read(5'h13, 12'h040, 2, 1'b0);
        do_read(5'h13, 12'h080, 2, 1'b1);
        for (int i = 0; i < 8; i++) do_read(5'h13, 12'h010, 2, 1'b0);

        for (int it = 0; it < 200; it++) begin
            if ($urandom % 16 == 0) begin
                new_mask = 4'($urandom);
                for (int c = 0; c < 4; c++)
                    if (ch_mask[c] && !new_mask[c]) q[c].delete();
                ch_mask = new_mask;
            end
            if ($urandom % 20 == 0) begin
                en = 1'b0;
                @(negedge clk);
                clear_all();
                en = 1'b1;
                @(negedge clk);
            end
            rch = ($urandom % 8 == 0) ? 5'($urandom) : 5'(16 + $urandom % 5);
            do_read(rch, 12'($urandom), 1 + int'($urandom % 6), ($urandom % 25) == 0);
        end
        chk("err_quiet", bus.err, 0);

`ifdef XADC_SEQ_TIMEOUT_EN
        ch_mask = 4'b1111;
        @(negedge clk);
        bus.eoc     = 1'b1;
        bus.channel = 5'h10;
        @(negedge clk);
        bus.eoc = 1'b0;
        chk("to_den", bus.den, 1);
        n = 0;
        while (!bus.err && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("to_cycles", n, 64);
        chk("to_busy", bus.busy, 0);
        do_read(5'h11, 12'h123, 2, 1'b0);
        chk("to_err_sticky", bus.err, 1);
`else
        n = 0;
`endif

        do_reset();
        chk("final_n", n, n == 0 ? 0 : 64);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
